// File: rtl/axi_id_remap_shrink.sv
// axi_id_remap_shrink: narrows wide slave-port AXI IDs to a small master-port ID
// space and restores the original ID on B and R responses.
// The write and read tables are independent. Each entry holds the original ID
// and an outstanding-transaction counter, so ordering per original ID is kept.
// Ports:
//   clk_i       clock
//   rst_ni      synchronous active-low reset
//   slv_req_i   requests from the upstream master (wide IDs)
//   slv_resp_o  responses to the upstream master (wide IDs restored)
//   mst_req_o   requests to the downstream slave (narrow IDs)
//   mst_resp_i  responses from the downstream slave (narrow IDs)

package axi_id_remap_shrink_pkg;
    localparam int unsigned SlvIdW = 6;
    localparam int unsigned MstIdW = 2;

    typedef struct packed {
        logic [SlvIdW-1:0] id;
        logic [31:0]       addr;
        logic [7:0]        len;
        logic [2:0]        size;
        logic [1:0]        burst;
    } slv_ax_t;

    typedef struct packed {
        logic [MstIdW-1:0] id;
        logic [31:0]       addr;
        logic [7:0]        len;
        logic [2:0]        size;
        logic [1:0]        burst;
    } mst_ax_t;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  strb;
        logic        last;
    } w_t;

    typedef struct packed { logic [SlvIdW-1:0] id; logic [1:0] resp; } slv_b_t;
    typedef struct packed { logic [MstIdW-1:0] id; logic [1:0] resp; } mst_b_t;

    typedef struct packed {
        logic [SlvIdW-1:0] id;
        logic [31:0]       data;
        logic [1:0]        resp;
        logic              last;
    } slv_r_t;

    typedef struct packed {
        logic [MstIdW-1:0] id;
        logic [31:0]       data;
        logic [1:0]        resp;
        logic              last;
    } mst_r_t;

    typedef struct packed {
        slv_ax_t aw; logic aw_valid; w_t w; logic w_valid; logic b_ready;
        slv_ax_t ar; logic ar_valid; logic r_ready;
    } slv_req_t;

    typedef struct packed {
        logic aw_ready; logic ar_ready; logic w_ready;
        slv_b_t b; logic b_valid; slv_r_t r; logic r_valid;
    } slv_resp_t;

    typedef struct packed {
        mst_ax_t aw; logic aw_valid; w_t w; logic w_valid; logic b_ready;
        mst_ax_t ar; logic ar_valid; logic r_ready;
    } mst_req_t;

    typedef struct packed {
        logic aw_ready; logic ar_ready; logic w_ready;
        mst_b_t b; logic b_valid; mst_r_t r; logic r_valid;
    } mst_resp_t;
endpackage

// Parameter sanity and protocol-error checks for one remap table.
module axi_id_remap_shrink_chk #(
    parameter int unsigned SlvIdWidth = 6,
    parameter int unsigned IdxWidth   = 2,
    parameter int unsigned MaxTxns    = 4
) (
    input logic clk,
    input logic rst_n,
    input logic rel_valid,
    input logic rel_cnt_zero
);
    if (IdxWidth >= SlvIdWidth) begin : g_bad_width
        $error("master-port ID width must be smaller than slave-port ID width");
    end
    if (MaxTxns < 1) begin : g_bad_txns
        $error("MaxTxnsPerId must be at least 1");
    end

    // A response for an entry with no outstanding transaction is a protocol error.
    always_ff @(posedge clk) begin
        if (rst_n && rel_valid) begin
            assert (!rel_cnt_zero) else $error("response ID refers to an idle table entry");
        end
    end
endmodule

// One remap table: ID lookup/allocation, lock of a stalled choice, counters.
module axi_id_remap_shrink_table #(
    parameter int unsigned SlvIdWidth = 6,
    parameter int unsigned IdxWidth   = 2,
    parameter int unsigned MaxTxns    = 4,
    parameter int unsigned CntWidth   = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    input  logic [SlvIdWidth-1:0] req_id,
    output logic                  req_ready,
    output logic                  out_valid,
    output logic [IdxWidth-1:0]   out_idx,
    input  logic                  out_ready,
    input  logic                  rel_valid,
    input  logic [IdxWidth-1:0]   rel_idx,
    output logic [SlvIdWidth-1:0] rel_slv_id
);
    localparam int unsigned TableSize = 2 ** IdxWidth;

    logic [CntWidth-1:0]   cnt_r    [TableSize];
    logic [SlvIdWidth-1:0] slv_id_r [TableSize];
    logic                  lock_valid_r;
    logic [IdxWidth-1:0]   lock_idx_r;

    logic                  hit_s, free_s, go_s, alloc_s, used_s, hs_s, rel_cnt_zero_s;
    logic [IdxWidth-1:0]   hit_idx_s, free_idx_s;

    // Search for a matching used entry and for the lowest-index unused entry.
    always_comb begin
        hit_s      = 1'b0;
        hit_idx_s  = '0;
        free_s     = 1'b0;
        free_idx_s = '0;
        used_s     = 1'b0;
        // Descending scan so the lowest matching index is the one kept.
        for (int i = TableSize - 1; i >= 0; i--) begin
            used_s = (cnt_r[i] != '0) || (lock_valid_r && (lock_idx_r == IdxWidth'(i)));
            if (used_s && (slv_id_r[i] == req_id)) begin
                hit_s     = 1'b1;
                hit_idx_s = IdxWidth'(i);
            end else if (!used_s) begin
                free_s     = 1'b1;
                free_idx_s = IdxWidth'(i);
            end else begin
                free_s = free_s;
            end
        end
    end

    // Choose the outgoing index: a held lock wins, then a hit, then a free entry.
    always_comb begin
        go_s    = 1'b0;
        out_idx = '0;
        alloc_s = 1'b0;
        if (lock_valid_r) begin
            go_s    = 1'b1;
            out_idx = lock_idx_r;
        end else if (hit_s) begin
            go_s    = (cnt_r[hit_idx_s] < CntWidth'(MaxTxns));
            out_idx = hit_idx_s;
        end else if (free_s) begin
            go_s    = 1'b1;
            out_idx = free_idx_s;
            alloc_s = 1'b1;
        end else begin
            go_s = 1'b0;
        end
    end

    assign out_valid      = req_valid && go_s;
    assign req_ready      = req_valid && go_s && out_ready;
    assign hs_s           = out_valid && out_ready;
    assign rel_slv_id     = slv_id_r[rel_idx];
    assign rel_cnt_zero_s = (cnt_r[rel_idx] == '0);

    // Table state: lock register, original-ID fields and outstanding counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lock_valid_r <= 1'b0;
            lock_idx_r   <= '0;
            for (int i = 0; i < TableSize; i++) begin
                cnt_r[i]    <= '0;
                slv_id_r[i] <= '0;
            end
        end else begin
            if (hs_s) begin
                lock_valid_r <= 1'b0;
            end else if (out_valid) begin
                lock_valid_r <= 1'b1;
                lock_idx_r   <= out_idx;
            end
            if (out_valid && alloc_s) begin
                slv_id_r[out_idx] <= req_id;
            end
            for (int i = 0; i < TableSize; i++) begin
                // Decrement saturates at zero on an illegal response.
                if ((hs_s && (out_idx == IdxWidth'(i))) &&
                    !(rel_valid && (rel_idx == IdxWidth'(i)) && (cnt_r[i] != '0))) begin
                    cnt_r[i] <= cnt_r[i] + CntWidth'(1);
                end else if (!(hs_s && (out_idx == IdxWidth'(i))) &&
                             (rel_valid && (rel_idx == IdxWidth'(i)) && (cnt_r[i] != '0))) begin
                    cnt_r[i] <= cnt_r[i] - CntWidth'(1);
                end
            end
        end
    end

    axi_id_remap_shrink_chk #(
        .SlvIdWidth(SlvIdWidth), .IdxWidth(IdxWidth), .MaxTxns(MaxTxns)
    ) u_chk (
        .clk(clk), .rst_n(rst_n), .rel_valid(rel_valid), .rel_cnt_zero(rel_cnt_zero_s)
    );
endmodule

module axi_id_remap_shrink #(
    parameter int unsigned AxiSlvPortIdWidth = 6,
    parameter int unsigned AxiMstPortIdWidth = 2,
    parameter int unsigned MaxTxnsPerId      = 4,
    parameter type slv_req_t  = axi_id_remap_shrink_pkg::slv_req_t,
    parameter type slv_resp_t = axi_id_remap_shrink_pkg::slv_resp_t,
    parameter type mst_req_t  = axi_id_remap_shrink_pkg::mst_req_t,
    parameter type mst_resp_t = axi_id_remap_shrink_pkg::mst_resp_t,
    localparam int unsigned CntWidth = $clog2(MaxTxnsPerId + 1)
) (
    input  logic      clk_i,
    input  logic      rst_ni,
    input  slv_req_t  slv_req_i,
    output slv_resp_t slv_resp_o,
    output mst_req_t  mst_req_o,
    input  mst_resp_t mst_resp_i
);
    logic                         aw_valid_s, aw_ready_s, ar_valid_s, ar_ready_s;
    logic [AxiMstPortIdWidth-1:0] aw_idx_s, ar_idx_s;
    logic [AxiSlvPortIdWidth-1:0] b_slv_id_s, r_slv_id_s;
    logic                         b_rel_s, r_rel_s;

    assign b_rel_s = mst_resp_i.b_valid && slv_req_i.b_ready;
    assign r_rel_s = mst_resp_i.r_valid && slv_req_i.r_ready && mst_resp_i.r.last;

    axi_id_remap_shrink_table #(
        .SlvIdWidth(AxiSlvPortIdWidth), .IdxWidth(AxiMstPortIdWidth),
        .MaxTxns(MaxTxnsPerId), .CntWidth(CntWidth)
    ) u_wr_table (
        .clk(clk_i), .rst_n(rst_ni),
        .req_valid(slv_req_i.aw_valid), .req_id(slv_req_i.aw.id), .req_ready(aw_ready_s),
        .out_valid(aw_valid_s), .out_idx(aw_idx_s), .out_ready(mst_resp_i.aw_ready),
        .rel_valid(b_rel_s), .rel_idx(mst_resp_i.b.id), .rel_slv_id(b_slv_id_s)
    );

    axi_id_remap_shrink_table #(
        .SlvIdWidth(AxiSlvPortIdWidth), .IdxWidth(AxiMstPortIdWidth),
        .MaxTxns(MaxTxnsPerId), .CntWidth(CntWidth)
    ) u_rd_table (
        .clk(clk_i), .rst_n(rst_ni),
        .req_valid(slv_req_i.ar_valid), .req_id(slv_req_i.ar.id), .req_ready(ar_ready_s),
        .out_valid(ar_valid_s), .out_idx(ar_idx_s), .out_ready(mst_resp_i.ar_ready),
        .rel_valid(r_rel_s), .rel_idx(mst_resp_i.r.id), .rel_slv_id(r_slv_id_s)
    );

    // Request path: pass through everything except the remapped IDs and gated valids.
    always_comb begin
        mst_req_o          = '0;
        mst_req_o.aw.id    = aw_idx_s;
        mst_req_o.aw.addr  = slv_req_i.aw.addr;
        mst_req_o.aw.len   = slv_req_i.aw.len;
        mst_req_o.aw.size  = slv_req_i.aw.size;
        mst_req_o.aw.burst = slv_req_i.aw.burst;
        mst_req_o.aw_valid = aw_valid_s;
        mst_req_o.w        = slv_req_i.w;
        mst_req_o.w_valid  = slv_req_i.w_valid;
        mst_req_o.b_ready  = slv_req_i.b_ready;
        mst_req_o.ar.id    = ar_idx_s;
        mst_req_o.ar.addr  = slv_req_i.ar.addr;
        mst_req_o.ar.len   = slv_req_i.ar.len;
        mst_req_o.ar.size  = slv_req_i.ar.size;
        mst_req_o.ar.burst = slv_req_i.ar.burst;
        mst_req_o.ar_valid = ar_valid_s;
        mst_req_o.r_ready  = slv_req_i.r_ready;
    end

    // Response path: restore original IDs from the tables.
    always_comb begin
        slv_resp_o          = '0;
        slv_resp_o.aw_ready = aw_ready_s;
        slv_resp_o.ar_ready = ar_ready_s;
        slv_resp_o.w_ready  = mst_resp_i.w_ready;
        slv_resp_o.b.id     = b_slv_id_s;
        slv_resp_o.b.resp   = mst_resp_i.b.resp;
        slv_resp_o.b_valid  = mst_resp_i.b_valid;
        slv_resp_o.r.id     = r_slv_id_s;
        slv_resp_o.r.data   = mst_resp_i.r.data;
        slv_resp_o.r.resp   = mst_resp_i.r.resp;
        slv_resp_o.r.last   = mst_resp_i.r.last;
        slv_resp_o.r_valid  = mst_resp_i.r_valid;
    end
endmodule

// File: tb/tb_axi_id_remap_shrink.sv
// Directed self-checking bench for axi_id_remap_shrink.
module tb_axi_id_remap_shrink;
    import axi_id_remap_shrink_pkg::*;

    logic      clk;
    logic      rst_n;
    slv_req_t  req;
    slv_resp_t sresp;
    mst_req_t  mreq;
    mst_resp_t mresp;

    int total = 0;
    int bad   = 0;

    axi_id_remap_shrink dut (
        .clk_i(clk), .rst_ni(rst_n),
        .slv_req_i(req), .slv_resp_o(sresp),
        .mst_req_o(mreq), .mst_resp_i(mresp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req.aw_valid   = 1'b0;
        req.ar_valid   = 1'b0;
        req.w_valid    = 1'b0;
        mresp.b_valid  = 1'b0;
        mresp.r_valid  = 1'b0;
        mresp.aw_ready = 1'b1;
        mresp.ar_ready = 1'b1;
        rst_n          = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic send_aw(input logic [5:0] id, input logic [1:0] idx);
        req.aw_valid = 1'b1;
        req.aw.id    = id;
        #1;
        check_eq("aw_ready", sresp.aw_ready, 1'b1);
        check_eq("aw_id", mreq.aw.id, idx);
        step();
        req.aw_valid = 1'b0;
    endtask

    task automatic send_ar(input logic [5:0] id, input logic [1:0] idx);
        req.ar_valid = 1'b1;
        req.ar.id    = id;
        #1;
        check_eq("ar_ready", sresp.ar_ready, 1'b1);
        check_eq("ar_id", mreq.ar.id, idx);
        step();
        req.ar_valid = 1'b0;
    endtask

    task automatic b_rsp(input logic [1:0] idx, input logic [5:0] exp_id);
        mresp.b_valid = 1'b1;
        mresp.b.id    = idx;
        #1;
        check_eq("b_id", sresp.b.id, exp_id);
        step();
        mresp.b_valid = 1'b0;
    endtask

    initial begin
        req   = '0;
        mresp = '0;
        req.b_ready    = 1'b1;
        req.r_ready    = 1'b1;
        mresp.w_ready  = 1'b1;
        do_reset();
        #1;
        check_eq("rst_aw_valid", mreq.aw_valid, 1'b0);
        check_eq("rst_ar_valid", mreq.ar_valid, 1'b0);
        check_eq("rst_aw_ready", sresp.aw_ready, 1'b0);
        check_eq("rst_ar_ready", sresp.ar_ready, 1'b0);

        // Basic remap with pass-through fields.
        req.aw.addr = 32'h0000_1000;
        req.aw.len  = 8'd2;
        req.aw_valid = 1'b1;
        req.aw.id    = 6'h2A;
        #1;
        check_eq("basic_aw_valid", mreq.aw_valid, 1'b1);
        check_eq("basic_aw_addr", mreq.aw.addr, 32'h0000_1000);
        check_eq("basic_aw_len", mreq.aw.len, 8'd2);
        send_aw(6'h2A, 2'd0);
        mresp.b.resp = 2'b10;
        #1;
        check_eq("basic_b_resp_idle", sresp.b_valid, 1'b0);
        mresp.b_valid = 1'b1;
        #1;
        check_eq("basic_b_valid", sresp.b_valid, 1'b1);
        check_eq("basic_b_resp", sresp.b.resp, 2'b10);
        b_rsp(2'd0, 6'h2A);

        // Hit reuse up to the per-entry limit; entry 0 must be free again.
        for (int i = 0; i < 4; i++) send_aw(6'h05, 2'd0);
        req.aw_valid = 1'b1;
        req.aw.id    = 6'h05;
        #1;
        check_eq("hit_stall_ready", sresp.aw_ready, 1'b0);
        check_eq("hit_stall_valid", mreq.aw_valid, 1'b0);
        // W channel passes straight through while AW is stalled.
        req.w_valid   = 1'b1;
        req.w.data    = 32'hDEAD_BEEF;
        mresp.w_ready = 1'b0;
        #1;
        check_eq("w_valid", mreq.w_valid, 1'b1);
        check_eq("w_data", mreq.w.data, 32'hDEAD_BEEF);
        check_eq("w_ready", sresp.w_ready, 1'b0);
        req.w_valid   = 1'b0;
        mresp.w_ready = 1'b1;
        step();
        mresp.b_valid = 1'b1;
        mresp.b.id    = 2'd0;
        #1;
        check_eq("hit_b_id", sresp.b.id, 6'h05);
        check_eq("hit_no_lookahead", sresp.aw_ready, 1'b0);
        step();
        mresp.b_valid = 1'b0;
        #1;
        check_eq("hit_resume_ready", sresp.aw_ready, 1'b1);
        check_eq("hit_resume_id", mreq.aw.id, 2'd0);
        step();
        req.aw_valid = 1'b0;

        // Read table full, then an entry frees on R last.
        do_reset();
        send_ar(6'h10, 2'd0);
        send_ar(6'h11, 2'd1);
        send_ar(6'h12, 2'd2);
        send_ar(6'h13, 2'd3);
        req.ar_valid = 1'b1;
        req.ar.id    = 6'h14;
        #1;
        check_eq("full_stall_ready", sresp.ar_ready, 1'b0);
        check_eq("full_stall_valid", mreq.ar_valid, 1'b0);
        step();
        mresp.r_valid = 1'b1;
        mresp.r.id    = 2'd2;
        mresp.r.last  = 1'b1;
        #1;
        check_eq("full_r_id", sresp.r.id, 6'h12);
        check_eq("full_no_lookahead", sresp.ar_ready, 1'b0);
        step();
        mresp.r_valid = 1'b0;
        #1;
        check_eq("full_resume_ready", sresp.ar_ready, 1'b1);
        check_eq("full_resume_id", mreq.ar.id, 2'd2);
        step();
        req.ar_valid = 1'b0;
        send_ar(6'h10, 2'd0);

        // Burst read: counter drops only on the last beat.
        do_reset();
        req.ar.len = 8'd3;
        send_ar(6'h07, 2'd0);
        for (int b = 0; b < 3; b++) begin
            mresp.r_valid = 1'b1;
            mresp.r.id    = 2'd0;
            mresp.r.last  = 1'b0;
            mresp.r.data  = 32'h100 + 32'(b);
            #1;
            check_eq("burst_r_id", sresp.r.id, 6'h07);
            check_eq("burst_r_data", sresp.r.data, 32'h100 + 32'(b));
            step();
        end
        mresp.r_valid = 1'b0;
        send_ar(6'h08, 2'd1);
        mresp.r_valid = 1'b1;
        mresp.r.last  = 1'b1;
        #1;
        check_eq("burst_last_id", sresp.r.id, 6'h07);
        check_eq("burst_last_flag", sresp.r.last, 1'b1);
        step();
        mresp.r_valid = 1'b0;
        send_ar(6'h09, 2'd0);

        // Lock: a stalled choice holds its index while other entries free.
        do_reset();
        send_aw(6'h20, 2'd0);
        mresp.aw_ready = 1'b0;
        req.aw_valid   = 1'b1;
        req.aw.id      = 6'h09;
        for (int c = 0; c < 5; c++) begin
            mresp.b_valid = (c == 2);
            mresp.b.id    = 2'd0;
            #1;
            check_eq("lock_valid", mreq.aw_valid, 1'b1);
            check_eq("lock_id", mreq.aw.id, 2'd1);
            step();
        end
        mresp.b_valid  = 1'b0;
        mresp.aw_ready = 1'b1;
        #1;
        check_eq("lock_hs_ready", sresp.aw_ready, 1'b1);
        check_eq("lock_hs_id", mreq.aw.id, 2'd1);
        step();
        req.aw_valid = 1'b0;
        b_rsp(2'd1, 6'h09);
        send_aw(6'h0A, 2'd0);

        // Reset with writes outstanding drops all table state.
        do_reset();
        send_aw(6'h30, 2'd0);
        send_aw(6'h31, 2'd1);
        send_aw(6'h32, 2'd2);
        do_reset();
        #1;
        check_eq("rst2_aw_valid", mreq.aw_valid, 1'b0);
        check_eq("rst2_aw_ready", sresp.aw_ready, 1'b0);
        send_aw(6'h33, 2'd0);
        send_aw(6'h34, 2'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/axi_id_remap_shrink.md
Name: axi_id_remap_shrink

Overview:
- Single-bus AXI ID remapper; the counterpart of ID prepending. It narrows wide slave-port IDs to a small master-port ID space and restores the original ID on B/R responses.
- Sits between a crossbar master port carrying prepended (wide) IDs and a downstream slave that supports only narrow IDs.
- Keeps separate write and read remap tables. Each entry holds {slv_id, outstanding counter}, so ordering per original ID is preserved.

Parameters:
- AxiSlvPortIdWidth, 6, ID width on slave port.
- AxiMstPortIdWidth, 2, ID width on master port; table depth TableSize = 2**AxiMstPortIdWidth.
- MaxTxnsPerId, 4, maximum outstanding transactions per table entry (>=1).
- slv_req_t, logic, AXI request struct on slave port (wide ID).
- slv_resp_t, logic, AXI response struct on slave port.
- mst_req_t, logic, AXI request struct on master port (narrow ID).
- mst_resp_t, logic, AXI response struct on master port.
- CntWidth, dependent (do not override), $clog2(MaxTxnsPerId+1).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset; synchronous, active-low.
- slv_req_i  in  slv_req_t  requests from upstream master.
- slv_resp_o  out  slv_resp_t  responses to upstream master.
- mst_req_o  out  mst_req_t  requests to downstream slave.
- mst_resp_i  in  mst_resp_t  responses from downstream slave.

Behaviour:
- **Reset:** one clk_i edge with rst_ni=0 clears all counters, slv_id fields and lock registers in both tables. All master valids and slave readies are then 0 until the slave side presents valids. Reset mid-transaction drops all table state and makes no attempt to complete outstanding transactions.
- **Latency:** zero-cycle, combinational through the data path. Only table state is registered.
- **Entry state:** an entry is "used" iff counter>0 or it is locked.
- **AW lookup (write table; AR is identical on the read table):**
  - Hit: a used entry with slv_id == aw.id. Use its index if counter < MaxTxnsPerId; otherwise stall.
  - Miss: allocate the lowest-index unused entry and write slv_id. If no unused entry exists, stall.
  - Stall: mst aw_valid=0, slv aw_ready=0.
  - Otherwise: mst aw_valid = slv aw_valid, slv aw_ready = mst aw_ready, mst aw.id = index, all other fields pass through unchanged.
- **Lock:** if mst aw_valid=1 and aw_ready=0, register the chosen index and hold it until handshake. Output ID and valid stay stable per AXI, even if table contents change meanwhile. A locked entry is never allocated to another ID.
- **Counters:**
  - +1 on the AW (AR) handshake.
  - −1 on the B handshake, or on the R handshake with r.last=1.
  - Increment and decrement on the same entry in the same cycle produce no net change.
  - An entry reaching 0 becomes free the next cycle. There is no same-cycle lookahead: a stalled miss cannot use an entry freed in that cycle.
- **W channel:** passed through unchanged (valid, ready, payload).
- **B/R responses:** slv b.id = write_table[b.id].slv_id and slv r.id = read_table[r.id].slv_id. All other fields, valid and ready pass through.
- **Illegal response:** a B or R carrying an ID of an entry with counter=0 is a protocol error. The counter saturates at 0 and a simulation assertion fires.
- **Elaboration asserts:** AxiMstPortIdWidth < AxiSlvPortIdWidth; MaxTxnsPerId >= 1.
- **Independence:** read and write tables are fully independent; simultaneous AW, AR, B and R events in one cycle are all legal.

Test Plan:
- **Basic remap:** AW id=0x2A, ready=1 → mst aw.id=0, cnt[0]=1. B id=0 → slv b.id=0x2A, cnt[0]=0.
- **Hit reuse:** 4 AWs id=0x05, MaxTxnsPerId=4 → all use index 0. 5th AW stalls (slv aw_ready=0) until one B id=0 handshakes, then it issues the next cycle.
- **Table full:** ARs ids 0x10, 0x11, 0x12, 0x13 occupy indices 0..3. AR id=0x14 stalls. R last id=2 → next cycle AR 0x14 goes out with id=2.
- **Burst read:** AR len=3 id=0x07 → counter decrements only on the 4th beat (r.last=1). All 4 R beats carry slv r.id=0x07.
- **Lock stability:** AW id=0x09 maps to index 1, held with mst aw_ready=0 for 5 cycles while B frees other entries → mst aw.id stays 1 and valid stays high.
- **Reset mid-flight:** 3 outstanding writes, then rst_ni=0 for 1 cycle → all counters 0. Next AW id=0x33 gets index 0.
